alu_32: RTL and testbench
=========================

// Module: alu_32
// PURPOSE
//   32-bit registered integer ALU for the datapath execute stage.
//   Combinationally computes one of 16 operations on port_A/port_B selected by opcode.
//   Captures result and N/Z/V flags in output registers on each rising clock edge.
//   Drives the writeback/branch logic.
// PARAMETERS
//   WIDTH  32  data width; flags and opcode map are defined for 32 only.
// PORTS
//   clk       in   1   single clock, rising-edge.
//   reset     in   1   asynchronous, active-high reset.
//   port_A    in   32  operand A.
//   port_B    in   32  operand B (shift amount = port_B[4:0]).
//   opcode    in   4   operation select.
//   out       out  32  registered result.
//   negative  out  1   registered out[31].
//   zero      out  1   registered (out == 0).
//   overflow  out  1   registered signed overflow (ADD/SUB only).
// BEHAVIOUR
// - Reset:
//   - reset=1 asynchronously forces out=0, negative=0, zero=1, overflow=0.
//   - These values hold while reset is high.
//   - The first capture occurs on the first rising clk after reset deasserts.
// - Latency:
//   - Operands/opcode sampled at rising clk; result visible 1 cycle later.
//   - Updated every cycle; no enable, no handshake.
// - Opcode map (sum/diff are modulo 2^32):
//   - 0 AND, 1 OR, 2 XOR, 3 NOR.
//   - 4 ADD A+B, 5 SUB A-B.
//   - 6 SLT: signed A<B -> 1, else 0. 7 SLTU: unsigned compare, same encoding.
//   - 8 SLL A<<B[4:0], 9 SRL logical, A SRA arithmetic (sign-fill).
//   - B pass A, C pass B, D NAND, E XNOR.
//   - F reserved -> out=0.
// - Flags:
//   - negative = result[31] for every opcode.
//   - zero = (result == 0) for every opcode.
//   - ADD overflow = A[31]==B[31] && result[31]!=A[31].
//   - SUB overflow = A[31]!=B[31] && result[31]!=A[31].
//   - overflow = 0 for all other opcodes.
//   - Carry-out is not exported.
// - Boundaries:
//   - Shift amount uses only B[4:0]; e.g. B=33 shifts by 1.
//   - A shift of 0 returns A unchanged.
//   - SLT/SLTU with A==B -> 0.
//   - X/Z on inputs is not defined.
//   - Reset asserted mid-stream clears outputs immediately, regardless of clk.
// TESTING
// - ADD A=5555AAAA B=44442222 -> out=9999CCCC, N=1 Z=0 V=1 after one clk.
// - SUB A=80000000 B=00000001 -> 7FFFFFFF, N=0 V=1; SUB A=B=12345678 -> 0, Z=1 V=0.
// - Logic: AND 5555AAAA,44442222 -> 44442222; XOR -> 11118888.
//   Logic: NOR 0,0 -> FFFFFFFF (N=1); opcode F -> 0 (Z=1).
// - Shifts: SRA 80000000 by 4 -> F8000000; SRL -> 08000000; SLL 1 by B=33 -> 2.
// - Compares:
//   - SLT A=FFFFFFFF B=1 -> 1; SLTU same operands -> 0.
//   - SLT A=B -> 0.
// - Reset: assert reset between clk edges with out=9999CCCC.
//   - Outputs go 0/0/1/0 immediately.
//   - They hold through clks while reset is high.
//   - First clk after release loads the new result.

Source files
------------

// File: rtl/alu_32.sv
// Registered 32-bit integer ALU: 16 opcodes on port_A/port_B, result and N/Z/V
// flags captured each rising clk edge, asynchronously cleared by reset.
module alu_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] port_A,
    input  logic [WIDTH-1:0] port_B,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] out,
    output logic             negative,
    output logic             zero,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_AND  = 4'h0,
        OP_OR   = 4'h1,
        OP_XOR  = 4'h2,
        OP_NOR  = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_SLT  = 4'h6,
        OP_SLTU = 4'h7,
        OP_SLL  = 4'h8,
        OP_SRL  = 4'h9,
        OP_SRA  = 4'hA,
        OP_PASA = 4'hB,
        OP_PASB = 4'hC,
        OP_NAND = 4'hD,
        OP_XNOR = 4'hE,
        OP_RSVD = 4'hF
    } op_e;

    op_e              op;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             arith_ovf;
    logic             lt_signed;
    logic             lt_unsigned;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] sra;
    logic [WIDTH-1:0] result;

    logic [WIDTH-1:0] out_d, out_q;
    logic             negative_d, negative_q;
    logic             zero_d, zero_q;
    logic             overflow_d, overflow_q;

    assign op = op_e'(opcode);

    // Shared adder: SUB is A + ~B + 1, so overflow uses the inverted B sign.
    always_comb begin
        is_sub    = (op == OP_SUB);
        b_eff     = is_sub ? ~port_B : port_B;
        sum       = port_A + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
        arith_ovf = (port_A[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum[WIDTH-1] != port_A[WIDTH-1]);
    end

    always_comb begin
        lt_signed   = ($signed(port_A) < $signed(port_B));
        lt_unsigned = (port_A < port_B);
    end

    always_comb begin
        shamt = port_B[SHW-1:0];
        shl   = port_A << shamt;
        shr   = port_A >> shamt;
        sra   = $signed(port_A) >>> shamt;
    end

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = port_A & port_B;
            OP_OR:   result = port_A | port_B;
            OP_XOR:  result = port_A ^ port_B;
            OP_NOR:  result = ~(port_A | port_B);
            OP_ADD:  result = sum;
            OP_SUB:  result = sum;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            OP_SLL:  result = shl;
            OP_SRL:  result = shr;
            OP_SRA:  result = sra;
            OP_PASA: result = port_A;
            OP_PASB: result = port_B;
            OP_NAND: result = ~(port_A & port_B);
            OP_XNOR: result = ~(port_A ^ port_B);
            default: result = '0;
        endcase
    end

    always_comb begin
        out_d      = result;
        negative_d = result[WIDTH-1];
        zero_d     = (result == '0);
        overflow_d = ((op == OP_ADD) || (op == OP_SUB)) && arith_ovf;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q      <= '0;
            negative_q <= 1'b0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            negative_q <= negative_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign out      = out_q;
    assign negative = negative_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_32.sv
// Self-checking bench for alu_32: directed vector table, reset sequences and
// randomized operations against an arithmetic reference model.
module tb_alu_32;

    logic        clk;
    logic        reset;
    logic [31:0] port_A;
    logic [31:0] port_B;
    logic [3:0]  opcode;
    logic [31:0] out;
    logic        negative;
    logic        zero;
    logic        overflow;

    int tests;
    int fails;

    alu_32 #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .port_A   (port_A),
        .port_B   (port_B),
        .opcode   (opcode),
        .out      (out),
        .negative (negative),
        .zero     (zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e_out;
        logic        e_n;
        logic        e_z;
        logic        e_v;
    } vec_t;

    // Reference model from plain signed/unsigned arithmetic; returns {out,N,Z,V}.
    function automatic logic [34:0] model(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, s, d;
        longint unsigned ua, ub, p;
        logic [31:0]     r;
        logic            v;
        int unsigned     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        sh = b % 32;
        p  = 64'd1 << sh;
        d  = longint'(p);
        r  = 32'h0;
        v  = 1'b0;
        s  = 0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a ^ b;
            4'h3: r = ~(a | b);
            4'h4: begin
                s = sa + sb;
                r = s[31:0];
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h5: begin
                s = sa - sb;
                r = s[31:0];
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h6: r = (sa < sb) ? 32'd1 : 32'd0;
            4'h7: r = (ua < ub) ? 32'd1 : 32'd0;
            4'h8: begin p = ua * p; r = p[31:0]; end
            4'h9: begin p = ua / p; r = p[31:0]; end
            4'hA: begin
                if (sa >= 0) s = sa / d;
                else         s = -((-sa + d - 1) / d);
                r = s[31:0];
            end
            4'hB: r = a;
            4'hC: r = b;
            4'hD: r = ~(a & b);
            4'hE: r = ~(a ^ b);
            default: r = 32'h0;
        endcase
        return {r, r[31], (r == 32'h0), v};
    endfunction

    task automatic check(input string name, input logic [34:0] exp);
        logic [34:0] act;
        act = {out, negative, zero, overflow};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got out=%08h N=%0b Z=%0b V=%0b, want out=%08h N=%0b Z=%0b V=%0b",
                     name, act[34:3], act[2], act[1], act[0],
                     exp[34:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        opcode = op;
        port_A = a;
        port_B = b;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  rop;
        tests = 0;
        fails = 0;

        vecs.push_back('{4'h4, 32'h5555AAAA, 32'h44442222, 32'h9999CCCC, 1, 0, 1});
        vecs.push_back('{4'h5, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 0, 1});
        vecs.push_back('{4'h5, 32'h12345678, 32'h12345678, 32'h00000000, 0, 1, 0});
        vecs.push_back('{4'h0, 32'h5555AAAA, 32'h44442222, 32'h44442222, 0, 0, 0});
        vecs.push_back('{4'h2, 32'h5555AAAA, 32'h44442222, 32'h11118888, 0, 0, 0});
        vecs.push_back('{4'h3, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1, 0, 0});
        vecs.push_back('{4'hF, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 0, 1, 0});
        vecs.push_back('{4'hA, 32'h80000000, 32'h00000004, 32'hF8000000, 1, 0, 0});
        vecs.push_back('{4'h9, 32'h80000000, 32'h00000004, 32'h08000000, 0, 0, 0});
        vecs.push_back('{4'h8, 32'h00000001, 32'h00000021, 32'h00000002, 0, 0, 0});
        vecs.push_back('{4'h8, 32'hA5A5A5A5, 32'h00000020, 32'hA5A5A5A5, 1, 0, 0});
        vecs.push_back('{4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0});
        vecs.push_back('{4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 1, 0});
        vecs.push_back('{4'h6, 32'h00000007, 32'h00000007, 32'h00000000, 0, 1, 0});
        vecs.push_back('{4'h7, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0});
        vecs.push_back('{4'h4, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 0, 1});
        vecs.push_back('{4'h1, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1, 0, 0});
        vecs.push_back('{4'hB, 32'h01234567, 32'h89ABCDEF, 32'h01234567, 0, 0, 0});
        vecs.push_back('{4'hC, 32'h01234567, 32'h89ABCDEF, 32'h89ABCDEF, 1, 0, 0});
        vecs.push_back('{4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 1, 0});
        vecs.push_back('{4'hE, 32'h5555AAAA, 32'h44442222, 32'hEEEE7777, 1, 0, 0});

        reset  = 1'b1;
        opcode = 4'h4;
        port_A = 32'h5555AAAA;
        port_B = 32'h44442222;
        #12;
        check("reset_state", {32'h0, 1'b0, 1'b1, 1'b0});
        reset = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_op%0h", i, vecs[i].op),
                  {vecs[i].e_out, vecs[i].e_n, vecs[i].e_z, vecs[i].e_v});
        end

        // Reset asserted between edges must clear at once and hold across clocks.
        apply(4'h4, 32'h5555AAAA, 32'h44442222);
        check("pre_reset_add", {32'h9999CCCC, 1'b1, 1'b0, 1'b1});
        #2 reset = 1'b1;
        #1;
        check("reset_async_clear", {32'h0, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
        check("reset_hold_1", {32'h0, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
        check("reset_hold_2", {32'h0, 1'b0, 1'b1, 1'b0});
        opcode = 4'h1;
        port_A = 32'h80000000;
        port_B = 32'h00000003;
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_load", {32'h80000003, 1'b1, 1'b0, 1'b0});

        for (int i = 0; i < 400; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom();
            rb  = $urandom();
            case ($urandom_range(0, 7))
                0: ra = 32'h80000000;
                1: rb = ra;
                2: ra = 32'h7FFFFFFF;
                3: rb = 32'hFFFFFFFF;
                default: ;
            endcase
            apply(rop, ra, rb);
            check($sformatf("rand%0d_op%0h_%08h_%08h", i, rop, ra, rb), model(rop, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
